// File: rtl/axis_downsizer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axis_downsizer : AXI-Stream width down-converter (wide beat -> words)  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module axis_downsizer #(
   parameter int WORD_W  = 8,
   parameter int S_BUS_W = 32,
   parameter int M_BUS_W = 8,
   localparam int S_WORDS = S_BUS_W / WORD_W,
   localparam int M_WORDS = M_BUS_W / WORD_W
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [S_WORDS-1:0][WORD_W-1:0]   s_data,
   input  logic [S_WORDS-1:0]               s_keep,
   input  logic                             s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [M_WORDS-1:0][WORD_W-1:0]   m_data,
   output logic [M_WORDS-1:0]               m_keep,
   output logic                             m_last
);

   localparam int R     = (M_WORDS > 0) ? (S_WORDS / M_WORDS) : 1;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

   generate
      if (WORD_W < 1 || M_BUS_W < WORD_W || S_BUS_W < M_BUS_W ||
          (S_BUS_W % WORD_W) != 0 || (M_BUS_W % WORD_W) != 0 ||
          (S_BUS_W % M_BUS_W) != 0) begin : g_bad_params
         $error("axis_downsizer: illegal WORD_W/S_BUS_W/M_BUS_W combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_EMPTY      = 2'd0,
      ST_EMIT       = 2'd1,
      ST_EMIT_FINAL = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [S_BUS_W-1:0]   r_data, w_data_nxt;
   logic [S_WORDS-1:0]   r_keep, w_keep_nxt;
   logic                 r_last, w_last_nxt;
   logic [R-1:0]         r_rem, w_rem_nxt;
   logic                 r_ready_en;
   logic [M_BUS_W-1:0]   r_m_data, w_m_data_nxt;
   logic [M_WORDS-1:0]   r_m_keep, w_m_keep_nxt;
   logic                 r_m_last, w_m_last_nxt;

   logic                 w_accept, w_advance;
   logic [S_BUS_W-1:0]   w_src_data;
   logic [S_WORDS-1:0]   w_src_keep;
   logic                 w_src_last;
   logic [R-1:0]         w_new_mask, w_src_mask, w_rest;
   logic                 w_found;
   logic [IDX_W-1:0]     w_idx;

   // A new beat may enter while the final sub-beat of the held one handshakes.
   assign s_ready   = r_ready_en &&
                      ((r_state == ST_EMPTY) || (m_ready && (r_state == ST_EMIT_FINAL)));
   assign w_accept  = s_valid && s_ready;
   assign w_advance = (r_state == ST_EMIT) && m_ready;

   assign w_src_data = w_accept ? s_data : r_data;
   assign w_src_keep = w_accept ? s_keep : r_keep;
   assign w_src_last = w_accept ? s_last : r_last;
   assign w_src_mask = w_accept ? w_new_mask : r_rem;

   always_comb begin
      w_new_mask = '0;
      for (int k = 0; k < R; k++) begin
         w_new_mask[k] = |s_keep[k*M_WORDS +: M_WORDS];
      end
   end

   // Lowest pending sub-beat goes out next; w_rest is what remains after it.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = R - 1; k >= 0; k--) begin
         if (w_src_mask[k]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(k);
         end
      end
      w_rest = w_src_mask;
      if (w_found) begin
         w_rest[w_idx] = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_data_nxt   = r_data;
      w_keep_nxt   = r_keep;
      w_last_nxt   = r_last;
      w_rem_nxt    = r_rem;
      w_m_data_nxt = r_m_data;
      w_m_keep_nxt = r_m_keep;
      w_m_last_nxt = r_m_last;
      if (w_accept) begin
         w_data_nxt = s_data;
         w_keep_nxt = s_keep;
         w_last_nxt = s_last;
      end
      if (w_accept || w_advance) begin
         if (w_found) begin
            w_m_data_nxt = w_src_data[w_idx*M_BUS_W +: M_BUS_W];
            w_m_keep_nxt = w_src_keep[w_idx*M_WORDS +: M_WORDS];
            w_m_last_nxt = w_src_last && (w_rest == '0);
            w_rem_nxt    = w_rest;
            w_state_nxt  = (w_rest == '0) ? ST_EMIT_FINAL : ST_EMIT;
         end else if (w_src_last) begin
            // Empty closing beat still carries the packet boundary.
            w_m_data_nxt = '0;
            w_m_keep_nxt = '0;
            w_m_last_nxt = 1'b1;
            w_rem_nxt    = '0;
            w_state_nxt  = ST_EMIT_FINAL;
         end else begin
            w_rem_nxt    = '0;
            w_state_nxt  = ST_EMPTY;
         end
      end else if ((r_state == ST_EMIT_FINAL) && m_ready) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_EMPTY;
         r_data     <= '0;
         r_keep     <= '0;
         r_last     <= 1'b0;
         r_rem      <= '0;
         r_ready_en <= 1'b0;
         r_m_data   <= '0;
         r_m_keep   <= '0;
         r_m_last   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_data     <= w_data_nxt;
         r_keep     <= w_keep_nxt;
         r_last     <= w_last_nxt;
         r_rem      <= w_rem_nxt;
         r_ready_en <= 1'b1;
         r_m_data   <= w_m_data_nxt;
         r_m_keep   <= w_m_keep_nxt;
         r_m_last   <= w_m_last_nxt;
      end
   end

   assign m_valid = (r_state != ST_EMPTY);
   assign m_data  = r_m_data;
   assign m_keep  = r_m_keep;
   assign m_last  = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_downsizer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | tb_axis_downsizer : directed and randomized bench for axis_downsizer   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_axis_downsizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn;
   logic            sel;
   logic            s_valid;
   logic [3:0][7:0] s_data;
   logic [3:0]      s_keep;
   logic            s_last;
   logic            m_ready;
   bit              rnd_ready;

   logic            a_sv, a_sr, a_mv, a_ml;
   logic [0:0][7:0] a_md;
   logic [0:0]      a_mk;
   logic            b_sv, b_sr, b_mv, b_ml;
   logic [1:0][7:0] b_md;
   logic [1:0]      b_mk;

   logic            mv, ml, sr;
   logic [15:0]     md;
   logic [1:0]      mk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
      int          cyc;
   } beat_t;
   beat_t rxq[$];

   assign a_sv = s_valid && !sel;
   assign b_sv = s_valid && sel;
   assign mv   = sel ? b_mv : a_mv;
   assign ml   = sel ? b_ml : a_ml;
   assign sr   = sel ? b_sr : a_sr;
   assign md   = sel ? 16'(b_md) : {8'h00, a_md};
   assign mk   = sel ? b_mk : {1'b0, a_mk};

   axis_downsizer #(.WORD_W(8), .S_BUS_W(32), .M_BUS_W(8)) u_dut8 (
      .clk(clk), .rstn(rstn),
      .s_valid(a_sv), .s_ready(a_sr), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
      .m_valid(a_mv), .m_ready(m_ready), .m_data(a_md), .m_keep(a_mk), .m_last(a_ml)
   );

   axis_downsizer #(.WORD_W(8), .S_BUS_W(32), .M_BUS_W(16)) u_dut16 (
      .clk(clk), .rstn(rstn),
      .s_valid(b_sv), .s_ready(b_sr), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
      .m_valid(b_mv), .m_ready(m_ready), .m_data(b_md), .m_keep(b_mk), .m_last(b_ml)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (rnd_ready) m_ready = ($urandom_range(9) == 0);

   // Output beats are logged just before the edge on which they handshake.
   always begin
      @(negedge clk);
      #4;
      if (rstn && mv && m_ready) rxq.push_back('{d: md, k: mk, l: ml, cyc: cyc});
   end

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge following acceptance.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t;
      bit hs;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      t  = 0;
      hs = 1'b0;
      while (!hs && t < 2000) begin
         #4;
         hs = sr;
         @(negedge clk);
         t++;
      end
      s_valid = 1'b0;
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL send_beat_timeout: s_ready=0 for %0d cycles, required handshake", t);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", a_mv); end
      checks++; if (a_ml !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", a_ml); end
      checks++; if (a_mk !== 1'b0) begin errors++; $display("FAIL reset_m_keep: got %b want 0", a_mk); end
      checks++; if (a_md !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", a_md); end
      checks++; if (a_sr !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", a_sr); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++; if (a_sr !== 1'b0) begin errors++; $display("FAIL reset_release_s_ready: got %b want 0", a_sr); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_sr !== 1'b1) begin errors++; $display("FAIL reset_ready_return: got %b want 1", a_sr); end
      @(negedge clk);
   endtask

   task automatic test_split();
      logic exp_sr;
      sel = 1'b0; m_ready = 1'b1; rxq.delete();
      send_beat(32'h44332211, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_sr = (i == 3);
         #4;
         checks++;
         if (sr !== exp_sr) begin errors++; $display("FAIL split_s_ready[%0d]: got %b want %b", i, sr, exp_sr); end
         @(negedge clk);
      end
      idle(4);
      checks++;
      if (rxq.size() != 4) begin
         errors++; $display("FAIL split_count: got %0d beats want 4", rxq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq[i].d !== 16'(8'h11 * (i + 1)) || rxq[i].k !== 2'b01 || rxq[i].l !== (i == 3) ||
                rxq[i].cyc !== rxq[0].cyc + i) begin
               errors++;
               $display("FAIL split_beat[%0d]: got d=%h k=%b l=%b cyc+%0d want d=%h k=01 l=%0d cyc+%0d",
                        i, rxq[i].d, rxq[i].k, rxq[i].l, rxq[i].cyc - rxq[0].cyc, 8'h11 * (i + 1), (i == 3), i);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ed[3];
      logic       el[3];
      ed = '{8'hAA, 8'hBB, 8'hCC};
      el = '{1'b0, 1'b1, 1'b1};
      rxq.delete();
      send_beat(32'h1234BBAA, 4'b0011, 1'b1);
      send_beat(32'h000000CC, 4'b0001, 1'b1);
      idle(5);
      checks++;
      if (rxq.size() != 3) begin
         errors++; $display("FAIL b2b_count: got %0d beats want 3", rxq.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxq[i].d !== 16'(ed[i]) || rxq[i].k !== 2'b01 || rxq[i].l !== el[i] || rxq[i].cyc !== rxq[0].cyc + i) begin
               errors++;
               $display("FAIL b2b_beat[%0d]: got d=%h l=%b cyc+%0d want d=%h l=%b cyc+%0d",
                        i, rxq[i].d, rxq[i].l, rxq[i].cyc - rxq[0].cyc, ed[i], el[i], i);
            end
         end
      end
   endtask

   task automatic test_sparse_keep();
      logic [7:0] ed[3];
      logic       el[3];
      ed = '{8'h11, 8'h33, 8'hDD};
      el = '{1'b0, 1'b0, 1'b1};
      rxq.delete();
      send_beat(32'h44332211, 4'b0101, 1'b0);
      send_beat(32'hDD000000, 4'b1000, 1'b1);
      idle(6);
      checks++;
      if (rxq.size() != 3) begin
         errors++; $display("FAIL sparse_count: got %0d beats want 3", rxq.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxq[i].d !== 16'(ed[i]) || rxq[i].k !== 2'b01 || rxq[i].l !== el[i]) begin
               errors++;
               $display("FAIL sparse_beat[%0d]: got d=%h k=%b l=%b want d=%h k=01 l=%b",
                        i, rxq[i].d, rxq[i].k, rxq[i].l, ed[i], el[i]);
            end
         end
      end
   endtask

   task automatic test_zero_keep();
      rxq.delete();
      send_beat(32'h12345678, 4'b0000, 1'b0);
      idle(4);
      checks++;
      if (rxq.size() != 0) begin errors++; $display("FAIL zero_keep_nolast: got %0d beats want 0", rxq.size()); end
      send_beat(32'h12345678, 4'b0000, 1'b1);
      idle(4);
      checks++;
      if (rxq.size() != 1) begin
         errors++; $display("FAIL zero_keep_last_count: got %0d beats want 1", rxq.size());
      end else begin
         checks++;
         if (rxq[0].d !== 16'h0000 || rxq[0].k !== 2'b00 || rxq[0].l !== 1'b1) begin
            errors++;
            $display("FAIL zero_keep_last_beat: got d=%h k=%b l=%b want d=00 k=00 l=1", rxq[0].d, rxq[0].k, rxq[0].l);
         end
      end
   endtask

   task automatic test_stall();
      rxq.delete();
      m_ready = 1'b0;
      send_beat(32'h44332211, 4'hF, 1'b1);
      for (int i = 0; i < 6; i++) begin
         #4;
         checks++;
         if (mv !== 1'b1 || md !== 16'h0011 || mk !== 2'b01 || ml !== 1'b0 || sr !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h k=%b l=%b s_ready=%b want v=1 d=11 k=01 l=0 s_ready=0",
                     i, mv, md, mk, ml, sr);
         end
         @(negedge clk);
      end
      m_ready = 1'b1;
      idle(6);
      checks++;
      if (rxq.size() != 4 || rxq[0].d !== 16'h0011 || rxq[3].d !== 16'h0044 || rxq[3].l !== 1'b1) begin
         errors++; $display("FAIL stall_drain: got %0d beats want 4 beats 11..44 ending in last", rxq.size());
      end
   endtask

   task automatic test_reset_mid_packet();
      rxq.delete();
      m_ready = 1'b1;
      send_beat(32'h44332211, 4'hF, 1'b1);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (a_mv !== 1'b0 || a_sr !== 1'b0) begin
         errors++; $display("FAIL midreset_drop: got m_valid=%b s_ready=%b want 0 0", a_mv, a_sr);
      end
      checks++;
      if (rxq.size() != 2) begin errors++; $display("FAIL midreset_pre_count: got %0d beats want 2", rxq.size()); end
      rxq.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (a_sr !== 1'b0 || a_mv !== 1'b0) begin
         errors++; $display("FAIL midreset_release: got s_ready=%b m_valid=%b want 0 0", a_sr, a_mv);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (a_sr !== 1'b1) begin errors++; $display("FAIL midreset_ready_return: got %b want 1", a_sr); end
      @(negedge clk);
      send_beat(32'hA4A3A2A1, 4'hF, 1'b1);
      idle(6);
      checks++;
      if (rxq.size() != 4) begin
         errors++; $display("FAIL midreset_after_count: got %0d beats want 4", rxq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq[i].d !== 16'(8'hA1 + i) || rxq[i].l !== (i == 3)) begin
               errors++;
               $display("FAIL midreset_after_beat[%0d]: got d=%h l=%b want d=%h l=%0d", i, rxq[i].d, rxq[i].l, 8'hA1 + i, (i == 3));
            end
         end
      end
   endtask

   // Reference: the flat list of kept words in send order and the packet count.
   task automatic test_random(input logic use16);
      logic [7:0]  expw[$];
      logic [7:0]  gotw[$];
      logic [3:0]  k;
      logic [31:0] d;
      int          wc, lasts, remw, t, nb, bad;
      sel = use16; rxq.delete();
      wc = 0; lasts = 0;
      rnd_ready = 1'b1;
      for (int p = 0; p < 20; p++) begin
         remw = $urandom_range(100, 1);
         while (remw > 0) begin
            k = ($urandom_range(3) != 0) ? 4'hF : 4'($urandom_range(15));
            d = $urandom;
            for (int w = 0; w < 4; w++) begin
               if (k[w] && remw > 0) begin
                  d[8*w +: 8] = 8'(wc);
                  expw.push_back(8'(wc));
                  wc++;
                  remw--;
               end else begin
                  k[w] = 1'b0;
               end
            end
            t = 0;
            while ($urandom_range(99) != 0 && t < 1000) begin
               @(negedge clk);
               t++;
            end
            send_beat(d, k, (remw == 0));
         end
      end
      t = 0;
      do begin
         @(negedge clk);
         #4;
         t++;
      end while (mv && t < 3000);
      rnd_ready = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      checks++;
      if (mv) begin errors++; $display("FAIL rand%0d_drain_timeout: m_valid still 1 after %0d cycles", use16, t); end
      nb = use16 ? 2 : 1;
      foreach (rxq[i]) begin
         for (int w = 0; w < nb; w++) if (rxq[i].k[w]) gotw.push_back(rxq[i].d[8*w +: 8]);
         if (rxq[i].l) lasts++;
      end
      checks++;
      if (gotw.size() != expw.size()) begin
         errors++; $display("FAIL rand%0d_word_count: got %0d want %0d", use16, gotw.size(), expw.size());
      end else begin
         bad = -1;
         foreach (expw[i]) if (bad < 0 && gotw[i] !== expw[i]) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++; $display("FAIL rand%0d_word_order: word %0d got %h want %h", use16, bad, gotw[bad], expw[bad]);
         end
      end
      checks++;
      if (lasts != 20) begin errors++; $display("FAIL rand%0d_packets: got %0d last beats want 20", use16, lasts); end
      checks++;
      if (rxq.size() == 0 || rxq[rxq.size()-1].l !== 1'b1) begin
         errors++; $display("FAIL rand%0d_final_last: final beat did not carry last (beats=%0d)", use16, rxq.size());
      end
   endtask

   initial begin
      rstn = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
      m_ready = 1'b0; rnd_ready = 1'b0;
      test_reset();
      test_split();
      test_back_to_back();
      test_sparse_keep();
      test_zero_keep();
      test_stall();
      test_reset_mid_packet();
      test_random(1'b0);
      test_random(1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
